// File: rtl/fetch_cache_pkg.sv
// Shared constants for the instruction fetch cache: address/line geometry and bus tag encodings.
package fetch_cache_pkg;

  localparam int unsigned ADDRESS_SIZE     = 64;
  localparam int unsigned INSTRUCTION_SIZE = 32;

  // A line is 64 bytes, delivered as 8 beats of 64 bits.
  localparam int unsigned LINE_BYTES     = 64;
  localparam int unsigned OFFSET_BITS    = 6;
  localparam int unsigned BEAT_BITS      = 64;
  localparam int unsigned BEATS_PER_LINE = 8;
  localparam int unsigned BEAT_CNT_BITS  = 3;
  localparam int unsigned LINE_BITS      = BEATS_PER_LINE * BEAT_BITS;

  // Bus tag fields: {READ, target[3:0], 8'h00}.
  localparam logic       SYSBUS_READ   = 1'b1;
  localparam logic [3:0] SYSBUS_MEMORY = 4'b0001;
  localparam logic [12:0] READ_MEM_TAG = {SYSBUS_READ, SYSBUS_MEMORY, 8'h00};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_FILL
  } state_t;

endpackage

// File: rtl/fetch_cache_array.sv
// Valid/tag/data storage: synchronous write port, asynchronous read port.
module fetch_cache_array
  import fetch_cache_pkg::*;
#(
  parameter int unsigned NUM_SETS = 256,
  parameter int unsigned IDX_W    = 8,
  parameter int unsigned TAG_W    = 50,
  parameter int unsigned LINE_W   = LINE_BITS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [LINE_W-1:0] wr_line,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [LINE_W-1:0] rd_line
);

  logic [NUM_SETS-1:0] valid_q;
  logic [TAG_W-1:0]    tag_mem  [NUM_SETS];
  logic [LINE_W-1:0]   data_mem [NUM_SETS];

  // Valid bits: cleared by reset, set when a fill completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Tag and line storage; contents are meaningless until the valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_line;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_line  = data_mem[rd_idx];

endmodule

// File: rtl/fetch_cache.sv
// Direct-mapped read-only instruction cache with 8-beat line refill over the system bus.
module fetch_cache
  import fetch_cache_pkg::*;
#(
  parameter int unsigned BUS_DATA_WIDTH = 64,
  parameter int unsigned BUS_TAG_WIDTH  = 13,
  parameter int unsigned ADDR_W         = 64,
  parameter int unsigned NUM_SETS       = 256
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      instruction_read,
  input  logic [ADDR_W-1:0]         instruction_address,
  output logic [31:0]               instruction_response,
  output logic                      busy,
  input  logic                      mem_read,
  input  logic                      mem_write,
  output logic                      bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_reqack,
  input  logic                      bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  output logic                      bus_respack
);

  localparam int unsigned IDX_W   = $clog2(NUM_SETS);
  localparam int unsigned TAG_W   = ADDR_W - OFFSET_BITS - IDX_W;
  localparam int unsigned BUF_W   = LINE_BITS - BUS_DATA_WIDTH;
  localparam logic [BEAT_CNT_BITS-1:0] LAST_BEAT = BEAT_CNT_BITS'(BEATS_PER_LINE - 1);

  state_t                   state;
  logic [BEAT_CNT_BITS-1:0] beat_cnt;
  logic [ADDR_W-1:0]        line_addr;
  logic [BUF_W-1:0]         line_buf;

  logic [IDX_W-1:0]     rd_idx;
  logic [TAG_W-1:0]     rd_tag_req;
  logic                 rd_valid;
  logic [TAG_W-1:0]     rd_tag_q;
  logic [LINE_BITS-1:0] rd_line;
  logic                 wr_en;
  logic [LINE_BITS-1:0] wr_line;
  logic                 hit;
  logic                 miss;
  logic [31:0]          word_sel;
  logic                 unused_inputs;

  assign rd_idx     = instruction_address[OFFSET_BITS +: IDX_W];
  assign rd_tag_req = instruction_address[ADDR_W-1 -: TAG_W];

  // Final beat bypasses the buffer and goes straight into the array with the first seven.
  assign wr_en   = !reset && (state == ST_FILL) && bus_respcyc && (beat_cnt == LAST_BEAT);
  assign wr_line = {bus_resp, line_buf};

  fetch_cache_array #(
    .NUM_SETS (NUM_SETS),
    .IDX_W    (IDX_W),
    .TAG_W    (TAG_W),
    .LINE_W   (LINE_BITS)
  ) u_array (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_idx   (line_addr[OFFSET_BITS +: IDX_W]),
    .wr_tag   (line_addr[ADDR_W-1 -: TAG_W]),
    .wr_line  (wr_line),
    .rd_idx   (rd_idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag_q),
    .rd_line  (rd_line)
  );

  // Lookup only happens in IDLE; a fill in progress always reports busy.
  assign hit      = (state == ST_IDLE) && instruction_read && rd_valid && (rd_tag_q == rd_tag_req);
  assign miss     = (state == ST_IDLE) && instruction_read && !hit;
  assign word_sel = rd_line[{instruction_address[5:2], 5'd0} +: 32];

  assign busy                 = !reset && ((state != ST_IDLE) || miss);
  assign instruction_response = (!reset && hit) ? word_sel : 32'd0;

  assign bus_reqcyc  = !reset && (state == ST_REQ);
  assign bus_req     = bus_reqcyc ? BUS_DATA_WIDTH'(line_addr) : '0;
  assign bus_reqtag  = bus_reqcyc ? BUS_TAG_WIDTH'(READ_MEM_TAG) : '0;
  assign bus_respack = !reset && (state == ST_FILL) && bus_respcyc;

  // Reserved data ports and the response tag carry no meaning for this cache.
  assign unused_inputs = ^{mem_read, mem_write, bus_resptag, instruction_address[1:0]};

  // Miss handling: latch the line, issue the request, collect beats.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      beat_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (miss) begin
            line_addr <= instruction_address & ~ADDR_W'(LINE_BYTES - 1);
            beat_cnt  <= '0;
            state     <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (bus_reqack) begin
            state <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (bus_respcyc) begin
            if (beat_cnt != LAST_BEAT) begin
              line_buf[{beat_cnt, 6'd0} +: BUS_DATA_WIDTH] <= bus_resp;
            end else begin
              state <= ST_IDLE;
            end
            beat_cnt <= beat_cnt + BEAT_CNT_BITS'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_cache.sv
// Self-checking bench for fetch_cache: vector table, directed corner cases, randomized fetches vs. a line-residency model.
module tb_fetch_cache;

  localparam int NSETS = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic        instruction_read;
  logic [63:0] instruction_address;
  logic [31:0] instruction_response;
  logic        busy;
  logic        mem_read;
  logic        mem_write;
  logic        bus_reqcyc;
  logic [63:0] bus_req;
  logic [12:0] bus_reqtag;
  logic        bus_reqack;
  logic        bus_respcyc;
  logic [63:0] bus_resp;
  logic [12:0] bus_resptag;
  logic        bus_respack;

  int checks   = 0;
  int failures = 0;

  // Which line address each set currently holds, if any.
  bit          ref_valid [NSETS];
  logic [63:0] ref_line  [NSETS];

  typedef struct {
    logic [63:0] addr;
    logic        exp_busy;
    logic [31:0] exp_resp;
  } vec_t;

  vec_t vecs [8];

  always #5 clk = ~clk;

  fetch_cache dut (
    .clk                  (clk),
    .reset                (reset),
    .instruction_read     (instruction_read),
    .instruction_address  (instruction_address),
    .instruction_response (instruction_response),
    .busy                 (busy),
    .mem_read             (mem_read),
    .mem_write            (mem_write),
    .bus_reqcyc           (bus_reqcyc),
    .bus_req              (bus_req),
    .bus_reqtag           (bus_reqtag),
    .bus_reqack           (bus_reqack),
    .bus_respcyc          (bus_respcyc),
    .bus_resp             (bus_resp),
    .bus_resptag          (bus_resptag),
    .bus_respack          (bus_respack)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Memory contents: line 0x1000 holds 0x0000001300000513 + k in beat k; other lines are offset copies.
  function automatic logic [63:0] beat_of(input logic [63:0] la, input int k);
    return 64'h0000_0013_0000_0513 + 64'(k) + ((la - 64'h1000) << 16);
  endfunction

  function automatic logic [31:0] exp_word(input logic [63:0] a);
    logic [63:0] b;
    b = beat_of(a & ~64'h3F, int'(a[5:3]));
    return a[2] ? b[63:32] : b[31:0];
  endfunction

  function automatic int idx_of(input logic [63:0] a);
    return int'(a[13:6]);
  endfunction

  function automatic bit model_hit(input logic [63:0] a);
    return ref_valid[idx_of(a)] && (ref_line[idx_of(a)] == (a & ~64'h3F));
  endfunction

  task automatic clear_model();
    for (int i = 0; i < NSETS; i++) ref_valid[i] = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    instruction_read = 1'b1;
    instruction_address = 64'h1000;
    bus_respcyc = 1'b0;
    bus_reqack = 1'b0;
    tick();
    tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_resp", 64'(instruction_response), 64'd0);
    chk("rst_reqcyc", 64'(bus_reqcyc), 64'd0);
    chk("rst_req", bus_req, 64'd0);
    chk("rst_reqtag", 64'(bus_reqtag), 64'd0);
    chk("rst_respack", 64'(bus_respack), 64'd0);
    reset = 1'b0;
    instruction_read = 1'b0;
    clear_model();
  endtask

  // Entered in the IDLE cycle where the miss was seen; returns one cycle after the last beat
  // (or after a reset pulse if stop_at < 8).
  task automatic serve_miss(input logic [63:0] la, input int min_gap, input int max_gap,
                            input bit wander, input int stop_at);
    logic [63:0] keep_addr;
    logic        keep_read;
    int          n;
    keep_addr = instruction_address;
    keep_read = instruction_read;
    tick();
    chk("req_cyc", 64'(bus_reqcyc), 64'd1);
    chk("req_addr", bus_req, la);
    chk("req_tag", 64'(bus_reqtag), 64'h1100);
    chk("req_busy", 64'(busy), 64'd1);
    n = $urandom_range(0, 2);
    for (int i = 0; i < n; i++) begin
      if (wander) instruction_read = 1'($urandom_range(0, 1));
      tick();
      chk("req_hold_cyc", 64'(bus_reqcyc), 64'd1);
      chk("req_hold_addr", bus_req, la);
      chk("req_hold_busy", 64'(busy), 64'd1);
    end
    bus_reqack = 1'b1;
    tick();
    bus_reqack = 1'b0;
    chk("fill_reqcyc", 64'(bus_reqcyc), 64'd0);
    chk("fill_req", bus_req, 64'd0);
    for (int k = 0; k < 8; k++) begin
      if (k == stop_at) begin
        reset = 1'b1;
        bus_respcyc = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_reqcyc", 64'(bus_reqcyc), 64'd0);
        chk("abort_respack", 64'(bus_respack), 64'd0);
        chk("abort_resp", 64'(instruction_response), 64'd0);
        tick();
        reset = 1'b0;
        clear_model();
        instruction_address = keep_addr;
        instruction_read = keep_read;
        return;
      end
      if (wander) begin
        instruction_address = {$urandom, $urandom} & ~64'h3;
        instruction_read = 1'($urandom_range(0, 1));
      end
      n = $urandom_range(min_gap, max_gap);
      for (int g = 0; g < n; g++) begin
        bus_respcyc = 1'b0;
        #1;
        chk("gap_respack", 64'(bus_respack), 64'd0);
        chk("gap_busy", 64'(busy), 64'd1);
        tick();
      end
      bus_respcyc = 1'b1;
      bus_resp = beat_of(la, k);
      #1;
      chk("beat_respack", 64'(bus_respack), 64'd1);
      chk("beat_busy", 64'(busy), 64'd1);
      tick();
    end
    bus_respcyc = 1'b0;
    bus_resp = '0;
    instruction_address = keep_addr;
    instruction_read = keep_read;
    ref_valid[idx_of(la)] = 1'b1;
    ref_line[idx_of(la)] = la;
  endtask

  // One fetch: hit checked directly, miss served and then re-checked as a hit.
  task automatic fetch(input logic [63:0] a, input int min_gap, input int max_gap, input bit wander);
    instruction_read = 1'b1;
    instruction_address = a;
    #1;
    if (model_hit(a)) begin
      chk("hit_busy", 64'(busy), 64'd0);
      chk("hit_resp", 64'(instruction_response), 64'(exp_word(a)));
      chk("hit_reqcyc", 64'(bus_reqcyc), 64'd0);
    end else begin
      chk("miss_busy", 64'(busy), 64'd1);
      serve_miss(a & ~64'h3F, min_gap, max_gap, wander, 8);
      #1;
      chk("post_fill_busy", 64'(busy), 64'd0);
      chk("post_fill_resp", 64'(instruction_response), 64'(exp_word(a)));
    end
    tick();
  endtask

  initial begin
    logic [63:0] base;
    int          sel;

    vecs[0] = '{64'h1000, 1'b0, 32'h0000_0513};
    vecs[1] = '{64'h1004, 1'b0, 32'h0000_0013};
    vecs[2] = '{64'h1008, 1'b0, 32'h0000_0514};
    vecs[3] = '{64'h100C, 1'b0, 32'h0000_0013};
    vecs[4] = '{64'h1020, 1'b0, 32'h0000_0517};
    vecs[5] = '{64'h1038, 1'b0, 32'h0000_051A};
    vecs[6] = '{64'h103C, 1'b0, 32'h0000_0013};
    vecs[7] = '{64'h1040, 1'b1, 32'h0000_0000};

    reset = 1'b1;
    instruction_read = 1'b0;
    instruction_address = '0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    bus_reqack = 1'b0;
    bus_respcyc = 1'b0;
    bus_resp = '0;
    bus_resptag = '0;

    do_reset();

    // Idle with no request.
    #1;
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_resp", 64'(instruction_response), 64'd0);
    tick();

    // Cold miss at 0x1000, back-to-back beats.
    fetch(64'h1000, 0, 0, 1'b0);

    // Whole line hits; next line misses.
    for (int i = 0; i < 8; i++) begin
      instruction_read = 1'b1;
      instruction_address = vecs[i].addr;
      #1;
      chk("vec_busy", 64'(busy), 64'(vecs[i].exp_busy));
      chk("vec_reqcyc", 64'(bus_reqcyc), 64'd0);
      if (!vecs[i].exp_busy) chk("vec_resp", 64'(instruction_response), 64'(vecs[i].exp_resp));
      if (i != 7) tick();
    end
    // Refill 0x1040 with 1-2 idle cycles between beats.
    serve_miss(64'h1040, 1, 2, 1'b0, 8);
    #1;
    chk("gapfill_busy", 64'(busy), 64'd0);
    chk("gapfill_resp", 64'(instruction_response), 64'(exp_word(64'h1040)));
    tick();
    fetch(64'h107C, 0, 0, 1'b0);

    // Conflict eviction in the same set.
    fetch(64'h1000 + 64'(64 * NSETS), 0, 1, 1'b0);
    instruction_address = 64'h1000;
    #1;
    chk("evicted_busy", 64'(busy), 64'd1);
    serve_miss(64'h1000, 0, 0, 1'b0, 8);
    #1;
    chk("refill_resp", 64'(instruction_response), 32'h0000_0513);
    tick();

    // Reset after beat 3 of a fill, then a full new request.
    do_reset();
    instruction_read = 1'b1;
    instruction_address = 64'h1000;
    #1;
    chk("cold_busy", 64'(busy), 64'd1);
    serve_miss(64'h1000, 0, 0, 1'b0, 4);
    instruction_read = 1'b1;
    instruction_address = 64'h1000;
    #1;
    chk("after_abort_busy", 64'(busy), 64'd1);
    serve_miss(64'h1000, 0, 0, 1'b0, 8);
    #1;
    chk("after_abort_resp", 64'(instruction_response), 32'h0000_0513);
    tick();

    // Randomized fetches across a few conflicting lines, with gaps and address wandering mid-fill.
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 5) == 0) begin
        instruction_read = 1'b0;
        instruction_address = {$urandom, $urandom};
        #1;
        chk("rnd_idle_busy", 64'(busy), 64'd0);
        chk("rnd_idle_resp", 64'(instruction_response), 64'd0);
        tick();
      end else begin
        sel = $urandom_range(0, 4);
        case (sel)
          0:       base = 64'h1000;
          1:       base = 64'h1040;
          2:       base = 64'h5000;
          3:       base = 64'h2FC0;
          default: base = 64'($urandom_range(0, 32'hFFFFF)) & ~64'h3F;
        endcase
        fetch(base + 64'($urandom_range(0, 15) * 4), 0, 2, 1'b1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
